// File: rtl/jump_base_responder_pkg.sv
// -----------------------------------------------------------------------------
// jump_base_responder_pkg
// Shared types and constants for the jump base responder: register index and
// data widths, and the encoding of the responder's control FSM.
// -----------------------------------------------------------------------------
package jump_base_responder_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    // Control FSM of the responder
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,   // ready for a new request
        ST_CHECK = 3'd1,   // first look at the hazard state of the base register
        ST_WAIT  = 3'd2,   // base register has a pending write, wait for writeback
        ST_READ  = 3'd3,   // register-file read data arrives this cycle
        ST_RESP  = 3'd4    // one-cycle ready pulse to the fetch side
    } jbr_state_e;

endpackage

// File: rtl/jump_base_responder.sv
// -----------------------------------------------------------------------------
// jump_base_responder
// Supplies the base value for a register-indirect jump to the fetch-side jump
// handler. The base register is checked against the scoreboard; a matching
// writeback broadcast is forwarded directly, a busy register is waited on, and
// an idle register is read from the register file. R0 always reads as zero.
//
// Ports
//   clk                      rising-edge clock
//   rst_n                    asynchronous active-low reset
//   jreq_valid / jreq_reg    jump request and its base register index
//   jreq_ready               high only while idle (request can be accepted)
//   busy_vec                 scoreboard pending-write bit per register
//   rf_rd_en / rf_rd_addr    register-file read request (one-cycle pulse)
//   rf_rd_data               register-file data, valid the cycle after rf_rd_en
//   wb_valid/wb_reg/wb_data  writeback broadcast
//   flush                    cancels any outstanding request
//   jump_base_from_rf_0      registered base value, held until next capture
//   jump_base_rdy_from_rf_0  one-cycle pulse when the base value is valid
// -----------------------------------------------------------------------------
module jump_base_responder
    import jump_base_responder_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 jreq_valid,
    input  logic [REG_IDX_W-1:0] jreq_reg,
    output logic                 jreq_ready,
    input  logic [NUM_REGS-1:0]  busy_vec,
    output logic                 rf_rd_en,
    output logic [REG_IDX_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0]    rf_rd_data,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic                 flush,
    output logic [DATA_W-1:0]    jump_base_from_rf_0,
    output logic                 jump_base_rdy_from_rf_0
);

    jbr_state_e           state_q;
    jbr_state_e           state_d;
    logic [REG_IDX_W-1:0] idx_q;
    logic [REG_IDX_W-1:0] idx_d;
    logic [DATA_W-1:0]    data_q;
    logic [DATA_W-1:0]    data_d;

    logic                 wb_hit_s;
    logic                 idx_busy_s;
    logic                 idx_zero_s;
    logic                 rd_en_s;

    // Hazard compare against the captured base register index
    assign wb_hit_s   = wb_valid && (wb_reg == idx_q);
    assign idx_busy_s = busy_vec[idx_q];
    assign idx_zero_s = (idx_q == {REG_IDX_W{1'b0}});

    // Next-state, capture and read-issue decisions
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        rd_en_s = 1'b0;

        if (flush) begin
            // Flush wins over acceptance, capture and read issue
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (jreq_valid) begin
                        idx_d   = jreq_reg;
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                ST_CHECK: begin
                    if (idx_zero_s) begin
                        data_d  = {DATA_W{1'b0}};
                        state_d = ST_RESP;
                    end else if (wb_hit_s) begin
                        // Forwarding beats both the busy bit and a read
                        data_d  = wb_data;
                        state_d = ST_RESP;
                    end else if (idx_busy_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        rd_en_s = 1'b1;
                        state_d = ST_READ;
                    end
                end

                ST_WAIT: begin
                    // No timeout: the writeback is guaranteed to arrive
                    if (wb_hit_s) begin
                        data_d  = wb_data;
                        state_d = ST_RESP;
                    end else if (!idx_busy_s) begin
                        rd_en_s = 1'b1;
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end

                ST_READ: begin
                    data_d  = rf_rd_data;
                    state_d = ST_RESP;
                end

                ST_RESP: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, captured index and base value registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= {REG_IDX_W{1'b0}};
            data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // The read address is driven only alongside the enable, zero otherwise
    assign rf_rd_en                = rd_en_s;
    assign rf_rd_addr              = rd_en_s ? idx_q : {REG_IDX_W{1'b0}};
    assign jreq_ready              = (state_q == ST_IDLE);
    assign jump_base_from_rf_0     = data_q;
    // A flush arriving in the response cycle suppresses the pulse
    assign jump_base_rdy_from_rf_0 = (state_q == ST_RESP) && !flush;

endmodule

// File: tb/tb_jump_base_responder.sv
// -----------------------------------------------------------------------------
// tb_jump_base_responder
// Directed scenarios followed by randomized traffic. A transaction-level
// reference model tracks the outstanding request (register, whether a read is
// in flight, whether the value is known) and predicts every output each cycle.
// Observed outputs are also logged per cycle for scenario-level timing checks.
// -----------------------------------------------------------------------------
module tb_jump_base_responder;
    import jump_base_responder_pkg::*;

    localparam int OBS_N = 8192;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jreq_valid;
    logic [3:0]  jreq_reg;
    logic        jreq_ready;
    logic [15:0] busy_vec;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_addr;
    logic [15:0] rf_rd_data;
    logic        wb_valid;
    logic [3:0]  wb_reg;
    logic [15:0] wb_data;
    logic        flush;
    logic [15:0] jump_base_from_rf_0;
    logic        jump_base_rdy_from_rf_0;

    jump_base_responder dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .jreq_valid              (jreq_valid),
        .jreq_reg                (jreq_reg),
        .jreq_ready              (jreq_ready),
        .busy_vec                (busy_vec),
        .rf_rd_en                (rf_rd_en),
        .rf_rd_addr              (rf_rd_addr),
        .rf_rd_data              (rf_rd_data),
        .wb_valid                (wb_valid),
        .wb_reg                  (wb_reg),
        .wb_data                 (wb_data),
        .flush                   (flush),
        .jump_base_from_rf_0     (jump_base_from_rf_0),
        .jump_base_rdy_from_rf_0 (jump_base_rdy_from_rf_0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Register file contents served by the bench
    logic [15:0] mem [16];
    logic        rd_seen;
    logic [3:0]  rd_addr_seen;

    // Per-cycle observation log
    logic        obs_rdy   [OBS_N];
    logic        obs_en    [OBS_N];
    logic [3:0]  obs_addr  [OBS_N];
    logic        obs_ready [OBS_N];
    logic [15:0] obs_data  [OBS_N];

    // Reference model of the outstanding request
    bit          m_act      = 1'b0;
    logic [3:0]  m_reg      = 4'd0;
    bit          m_rd_pend  = 1'b0;
    bit          m_resp_pend = 1'b0;
    logic [15:0] m_data     = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Predict this cycle's outputs, compare, then advance the model
    task automatic model_step();
        logic        e_rdy;
        logic        e_en;
        logic        e_ready;
        logic [3:0]  e_addr;
        bit          resolve;
        logic [15:0] new_val;
        e_rdy   = 1'b0;
        e_en    = 1'b0;
        e_ready = 1'b0;
        e_addr  = 4'd0;
        resolve = 1'b0;
        new_val = 16'h0000;

        rd_seen      = rf_rd_en;
        rd_addr_seen = rf_rd_addr;
        if (cyc < OBS_N) begin
            obs_rdy[cyc]   = jump_base_rdy_from_rf_0;
            obs_en[cyc]    = rf_rd_en;
            obs_addr[cyc]  = rf_rd_addr;
            obs_ready[cyc] = jreq_ready;
            obs_data[cyc]  = jump_base_from_rf_0;
        end

        if (!rst_n) begin
            m_act   = 1'b0;
            m_data  = 16'h0000;
            e_ready = 1'b1;
        end else if (!m_act) begin
            e_ready = 1'b1;
            if (jreq_valid && !flush) begin
                m_act       = 1'b1;
                m_reg       = jreq_reg;
                m_rd_pend   = 1'b0;
                m_resp_pend = 1'b0;
            end
        end else if (flush) begin
            m_act = 1'b0;
        end else if (m_resp_pend) begin
            e_rdy = 1'b1;
            m_act = 1'b0;
        end else if (m_rd_pend) begin
            resolve = 1'b1;
            new_val = mem[m_reg];
        end else if (m_reg == 4'd0) begin
            resolve = 1'b1;
            new_val = 16'h0000;
        end else if (wb_valid && wb_reg == m_reg) begin
            resolve = 1'b1;
            new_val = wb_data;
        end else if (!busy_vec[m_reg]) begin
            e_en      = 1'b1;
            e_addr    = m_reg;
            m_rd_pend = 1'b1;
        end

        chk("rdy",   32'(jump_base_rdy_from_rf_0), 32'(e_rdy));
        chk("rd_en", 32'(rf_rd_en), 32'(e_en));
        chk("ready", 32'(jreq_ready), 32'(e_ready));
        chk("data",  32'(jump_base_from_rf_0), 32'(m_data));
        if (e_en || !rst_n) begin
            chk("rd_addr", 32'(rf_rd_addr), 32'(e_addr));
        end

        if (resolve) begin
            m_data      = new_val;
            m_resp_pend = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        rf_rd_data = rd_seen ? mem[rd_addr_seen] : 16'($urandom);
        cyc = cyc + 1;
    endtask

    task automatic idle_inputs();
        rst_n      = 1'b1;
        jreq_valid = 1'b0;
        jreq_reg   = 4'd0;
        busy_vec   = 16'h0000;
        wb_valid   = 1'b0;
        wb_reg     = 4'd0;
        wb_data    = 16'h0000;
        flush      = 1'b0;
    endtask

    // Hold the request until the model says it has been answered
    task automatic serve(input int max_cyc);
        for (int k = 0; k < max_cyc; k++) begin
            cycle();
            if (!m_act) begin
                jreq_valid = 1'b0;
                break;
            end
        end
        jreq_valid = 1'b0;
    endtask

    function automatic int count_en(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) n += int'(obs_en[k]);
        return n;
    endfunction

    function automatic int count_rdy(input int a, input int b);
        int n = 0;
        for (int k = a; k <= b; k++) n += int'(obs_rdy[k]);
        return n;
    endfunction

    initial begin
        int          t0;
        logic [15:0] one_bit;
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
        idle_inputs();
        rst_n      = 1'b0;
        rf_rd_data = 16'h0000;

        // Reset state
        for (int k = 0; k < 3; k++) cycle();
        chk("rst_ready", 32'(obs_ready[1]), 32'd1);
        chk("rst_data",  32'(obs_data[1]),  32'd0);
        rst_n = 1'b1;
        cycle();

        // Plain read of R5
        idle_inputs();
        mem[5] = 16'h1234;
        jreq_valid = 1'b1; jreq_reg = 4'd5; t0 = cyc;
        serve(8);
        cycle();
        chk("s1_en_t1",   32'(obs_en[t0+1]),   32'd1);
        chk("s1_addr_t1", 32'(obs_addr[t0+1]), 32'd5);
        chk("s1_rdy_t3",  32'(obs_rdy[t0+3]),  32'd1);
        chk("s1_data_t3", 32'(obs_data[t0+3]), 32'h1234);
        chk("s1_rdy_cnt", 32'(count_rdy(t0, t0+4)), 32'd1);

        // R0 reads zero without a register-file access
        jreq_valid = 1'b1; jreq_reg = 4'd0; t0 = cyc;
        serve(8);
        cycle();
        chk("s3_rdy_t2",  32'(obs_rdy[t0+2]),  32'd1);
        chk("s3_data_t2", 32'(obs_data[t0+2]), 32'h0000);
        chk("s3_no_rd",   32'(count_en(t0, t0+3)), 32'd0);

        // Busy R3 resolved by a writeback four cycles after the request
        busy_vec = 16'h0008;
        jreq_valid = 1'b1; jreq_reg = 4'd3; t0 = cyc;
        for (int k = 0; k < 4; k++) cycle();
        wb_valid = 1'b1; wb_reg = 4'd3; wb_data = 16'hBEEF;
        cycle();
        wb_valid = 1'b0;
        cycle();
        jreq_valid = 1'b0; busy_vec = 16'h0000;
        cycle();
        chk("s2_rdy_t5",  32'(obs_rdy[t0+5]),  32'd1);
        chk("s2_data_t5", 32'(obs_data[t0+5]), 32'hBEEF);
        chk("s2_no_early", 32'(count_rdy(t0, t0+4)), 32'd0);
        chk("s2_no_rd",   32'(count_en(t0, t0+6)), 32'd0);

        // Flush while waiting on busy R7, then a normal request for R2
        busy_vec = 16'h0080;
        jreq_valid = 1'b1; jreq_reg = 4'd7; t0 = cyc;
        for (int k = 0; k < 3; k++) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0; jreq_valid = 1'b0;
        cycle();
        cycle();
        chk("s4_ready_t4", 32'(obs_ready[t0+4]), 32'd1);
        chk("s4_hold",     32'(obs_data[t0+4]),  32'hBEEF);
        chk("s4_no_rdy",   32'(count_rdy(t0, t0+5)), 32'd0);
        busy_vec = 16'h0000; mem[2] = 16'h5A5A;
        jreq_valid = 1'b1; jreq_reg = 4'd2; t0 = cyc;
        serve(8);
        cycle();
        chk("s4b_addr_t1", 32'(obs_addr[t0+1]), 32'd2);
        chk("s4b_rdy_t3",  32'(obs_rdy[t0+3]),  32'd1);
        chk("s4b_data_t3", 32'(obs_data[t0+3]), 32'h5A5A);

        // Busy R9: unrelated writeback ignored, read once busy clears
        busy_vec = 16'h0200; mem[9] = 16'h0909;
        jreq_valid = 1'b1; jreq_reg = 4'd9; t0 = cyc;
        cycle(); cycle();
        wb_valid = 1'b1; wb_reg = 4'd4; wb_data = 16'hDEAD;
        cycle(); cycle();
        wb_valid = 1'b0;
        cycle();
        busy_vec = 16'h0000;
        cycle(); cycle(); cycle();
        jreq_valid = 1'b0;
        cycle();
        chk("s5_waiting",  32'(obs_ready[t0+4]), 32'd0);
        chk("s5_wb_ign",   32'(obs_data[t0+4]),  32'h5A5A);
        chk("s5_no_rd",    32'(count_en(t0, t0+4)), 32'd0);
        chk("s5_en_t5",    32'(obs_en[t0+5]),   32'd1);
        chk("s5_addr_t5",  32'(obs_addr[t0+5]), 32'd9);
        chk("s5_rdy_t7",   32'(obs_rdy[t0+7]),  32'd1);
        chk("s5_data_t7",  32'(obs_data[t0+7]), 32'h0909);
        chk("s5_no_early", 32'(count_rdy(t0, t0+6)), 32'd0);

        // Reset asserted while in READ
        mem[6] = 16'h6666;
        jreq_valid = 1'b1; jreq_reg = 4'd6; t0 = cyc;
        cycle(); cycle();
        rst_n = 1'b0;
        cycle(); cycle();
        rst_n = 1'b1; jreq_valid = 1'b0;
        for (int k = 0; k < 5; k++) cycle();
        chk("s6_ready", 32'(obs_ready[t0+2]), 32'd1);
        chk("s6_en",    32'(obs_en[t0+2]),    32'd0);
        chk("s6_data",  32'(obs_data[t0+2]),  32'd0);
        chk("s6_no_rdy", 32'(count_rdy(t0, t0+8)), 32'd0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) begin
                one_bit  = 16'h0001;
                busy_vec = busy_vec ^ (one_bit << $urandom_range(15));
            end
            wb_valid = ($urandom_range(3) == 0);
            wb_reg   = ($urandom_range(1) == 0) ? m_reg : 4'($urandom);
            wb_data  = 16'($urandom);
            flush    = ($urandom_range(39) == 0);
            rst_n    = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
            if (m_act) begin
                jreq_valid = 1'b1;
                jreq_reg   = 4'($urandom);
            end else begin
                jreq_valid = ($urandom_range(1) == 0);
                jreq_reg   = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
